stream_argmax: RTL and testbench

- Sequential, parametrised successor to the combinational 10-way argmax used at the classifier output.
- Accepts one class score per cycle over a valid/ready stream and tracks the running maximum and its index.
- Presents {index, max value, tie flag} on a held output handshake once NUM_CLASSES scores have been consumed.
- Sits between the final-layer accumulator and the result register/host interface.

---
 rtl/argmax_pkg.sv | 20 ++
 rtl/score_cmp.sv | 25 ++
 rtl/stream_argmax.sv | 111 +++++++++++
 tb/tb_stream_argmax.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/argmax_pkg.sv
// Shared definitions for the streaming argmax block.
//   state_t          : FSM state encoding (ACCUM collects scores, DONE holds a result)
//   DEF_NUM_SIZE     : default score width, shared with the classifier top
//   DEF_NUM_CLASSES  : default scores per frame, shared with the classifier top
//   idx_width(n)     : index width needed to address n classes
package argmax_pkg;

   localparam int DEF_NUM_SIZE    = 26;
   localparam int DEF_NUM_CLASSES = 10;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   function automatic int idx_width(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/score_cmp.sv
// Combinational score comparator.
//   a, b : NUM_SIZE-wide operands
//   gt   : a > b (two's complement when SIGNED_CMP = 1, unsigned otherwise)
//   eq   : a == b (bit-identical)
module score_cmp #(
   parameter int NUM_SIZE   = 26,
   parameter bit SIGNED_CMP = 1'b0
) (
   input  logic [NUM_SIZE-1:0] a,
   input  logic [NUM_SIZE-1:0] b,
   output logic                gt,
   output logic                eq
);

   generate
      if (SIGNED_CMP) begin : g_signed
         assign gt = ($signed(a) > $signed(b));
      end else begin : g_unsigned
         assign gt = (a > b);
      end
   endgenerate

   assign eq = (a == b);

endmodule

// File: rtl/stream_argmax.sv
// Streaming argmax: consumes one score per accepted beat, tracks the running
// maximum and its index, and presents the result once NUM_CLASSES scores of a
// frame have been accepted.
//   clk, GlobalReset : clock, asynchronous active-high reset
//   Flush            : synchronous frame abort (wins over accept and output handshake)
//   in_valid/in_ready/in_data    : score stream, in_data is the score for class = count
//   out_valid/out_ready          : result handshake, result held until accepted
//   out_index/out_max/out_tie    : argmax index, max score, later-equal-to-max flag
//
// state | meaning
// ACCUM | accepting scores, out_* hold running values
// DONE  | frame complete, result held until out_ready
module stream_argmax
   import argmax_pkg::*;
#(
   parameter int NUM_SIZE    = DEF_NUM_SIZE,
   parameter int NUM_CLASSES = DEF_NUM_CLASSES,
   parameter bit SIGNED_CMP  = 1'b0,
   parameter int IDX_W       = idx_width(NUM_CLASSES)
) (
   input  logic                clk,
   input  logic                GlobalReset,
   input  logic                Flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NUM_SIZE-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [IDX_W-1:0]    out_index,
   output logic [NUM_SIZE-1:0] out_max,
   output logic                out_tie
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    count;
   logic [NUM_SIZE-1:0] max_r;
   logic [IDX_W-1:0]    idx_r;
   logic                tie_r;
   logic                accept;
   logic                last_beat;
   logic                cmp_gt, cmp_eq;

   score_cmp #(
      .NUM_SIZE   (NUM_SIZE),
      .SIGNED_CMP (SIGNED_CMP)
   ) u_cmp (
      .a  (in_data),
      .b  (max_r),
      .gt (cmp_gt),
      .eq (cmp_eq)
   );

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && (state == ACCUM) && !Flush;
   assign last_beat = (count == LAST_IDX);

   always_ff @(posedge clk or posedge GlobalReset) begin
      if (GlobalReset) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (Flush) begin
         state_nxt = ACCUM;
      end else begin
         case (state)
            ACCUM: if (accept && last_beat) state_nxt = DONE;
            DONE:  if (out_ready)           state_nxt = ACCUM;
            default: state_nxt = ACCUM;
         endcase
      end
   end

   // The first beat of a frame loads unconditionally so stale values from a
   // previous or flushed frame never leak into the new result.
   always_ff @(posedge clk or posedge GlobalReset) begin
      if (GlobalReset) begin
         count <= '0;
         max_r <= '0;
         idx_r <= '0;
         tie_r <= 1'b0;
      end else if (Flush) begin
         count <= '0;
      end else if (accept) begin
         count <= last_beat ? '0 : count + IDX_W'(1);
         if (count == '0) begin
            max_r <= in_data;
            idx_r <= '0;
            tie_r <= 1'b0;
         end else if (cmp_gt) begin
            max_r <= in_data;
            idx_r <= count;
            tie_r <= 1'b0;
         end else if (cmp_eq) begin
            tie_r <= 1'b1;
         end
      end
   end

   assign out_index = idx_r;
   assign out_max   = max_r;
   assign out_tie   = tie_r;

endmodule

// File: tb/tb_stream_argmax.sv
module tb_stream_argmax;

   localparam int NS = 26;
   localparam int NC = 10;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          GlobalReset = 1'b1;
   logic          Flush = 1'b0;
   logic          in_valid = 1'b0;
   logic [NS-1:0] in_data = '0;
   logic          out_ready = 1'b0;

   logic          in_ready, out_valid, out_tie;
   logic [IW-1:0] out_index;
   logic [NS-1:0] out_max;

   logic          s_in_ready, s_out_valid, s_out_tie;
   logic [IW-1:0] s_out_index;
   logic [NS-1:0] s_out_max;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stream_argmax #(.NUM_SIZE(NS), .NUM_CLASSES(NC), .SIGNED_CMP(1'b0)) dut (
      .clk(clk), .GlobalReset(GlobalReset), .Flush(Flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_index(out_index), .out_max(out_max), .out_tie(out_tie)
   );

   stream_argmax #(.NUM_SIZE(NS), .NUM_CLASSES(NC), .SIGNED_CMP(1'b1)) dut_s (
      .clk(clk), .GlobalReset(GlobalReset), .Flush(Flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .out_index(s_out_index), .out_max(s_out_max), .out_tie(s_out_tie)
   );

   // Stimulus only: drives one score per cycle with in_valid held high.
   task automatic drive_frame(input int sc[NC]);
      for (int i = 0; i < NC; i++) begin
         in_valid = 1'b1;
         in_data  = sc[i][NS-1:0];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      GlobalReset = 1'b1;
      #2;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      n_vec++; if ({out_index, out_max, out_tie} !== '0) begin n_err++;
         $display("FAIL reset_outputs got idx %0d max %0d tie %b exp 0", out_index, out_max, out_tie); end
      @(posedge clk); #1;
      GlobalReset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_ties();
      int sc[NC] = '{5, 9, 3, 9, 1, 0, 2, 8, 7, 4};
      for (int i = 0; i < NC; i++) begin
         n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ties_early_valid beat %0d got %b exp 0", i, out_valid); end
         in_valid = 1'b1; in_data = sc[i][NS-1:0];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ties_valid got %b exp 1", out_valid); end
      n_vec++; if (out_index !== 4'd1) begin n_err++; $display("FAIL ties_index got %0d exp 1", out_index); end
      n_vec++; if (out_max !== 26'd9) begin n_err++; $display("FAIL ties_max got %0d exp 9", out_max); end
      n_vec++; if (out_tie !== 1'b1) begin n_err++; $display("FAIL ties_tie got %b exp 1", out_tie); end
      take_result();
      n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
         $display("FAIL ties_release got valid %b ready %b exp 0 1", out_valid, in_ready); end
   endtask

   task automatic test_hold();
      int sc[NC] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
      drive_frame(sc);
      // Offer an input during DONE; it must not be taken.
      in_valid = 1'b1; in_data = 26'd100;
      for (int c = 0; c < 5; c++) begin
         n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++;
            $display("FAIL hold_hs cyc %0d got valid %b ready %b exp 1 0", c, out_valid, in_ready); end
         n_vec++; if (out_index !== 4'd9 || out_max !== 26'd9 || out_tie !== 1'b0) begin n_err++;
            $display("FAIL hold_result cyc %0d got idx %0d max %0d tie %b exp 9 9 0", c, out_index, out_max, out_tie); end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      take_result();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release got %b exp 0", out_valid); end
   endtask

   task automatic test_signed();
      int sc[NC] = '{-1, -5, -2, -1, -100, -3, -7, -9, -8, -6};
      drive_frame(sc);
      n_vec++; if (s_out_valid !== 1'b1 || s_out_index !== 4'd0 || s_out_max !== 26'h3FFFFFF || s_out_tie !== 1'b1) begin n_err++;
         $display("FAIL signed_result got v %b idx %0d max %h tie %b exp 1 0 3ffffff 1", s_out_valid, s_out_index, s_out_max, s_out_tie); end
      n_vec++; if (out_valid !== 1'b1 || out_index !== 4'd0 || out_max !== 26'h3FFFFFF || out_tie !== 1'b1) begin n_err++;
         $display("FAIL unsigned_neg_result got v %b idx %0d max %h tie %b exp 1 0 3ffffff 1", out_valid, out_index, out_max, out_tie); end
      take_result();
   endtask

   task automatic test_signed_order();
      // Positive beats negative only in signed mode.
      int sc[NC] = '{-4, 3, -9, 1, 2, 0, -1, 2, 1, -2};
      drive_frame(sc);
      n_vec++; if (s_out_index !== 4'd1 || s_out_max !== 26'd3 || s_out_tie !== 1'b0) begin n_err++;
         $display("FAIL signed_order got idx %0d max %h tie %b exp 1 3 0", s_out_index, s_out_max, s_out_tie); end
      n_vec++; if (out_index !== 4'd6 || out_max !== 26'h3FFFFFF || out_tie !== 1'b0) begin n_err++;
         $display("FAIL unsigned_order got idx %0d max %h tie %b exp 6 3ffffff 0", out_index, out_max, out_tie); end
      take_result();
   endtask

   task automatic test_bubbles();
      int sc[NC] = '{3, 1, 4, 1, 5, 9, 20, 2, 6, 5};
      for (int i = 0; i < NC; i++) begin
         in_valid = 1'b1; in_data = sc[i][NS-1:0];
         @(posedge clk); #1;
         in_valid = 1'b0; in_data = 26'd999;
         for (int b = 0; b < 2; b++) begin
            @(posedge clk); #1;
            if (i < NC - 1) begin
               n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_early_valid beat %0d got %b exp 0", i, out_valid); end
            end
         end
      end
      n_vec++; if (out_valid !== 1'b1 || out_index !== 4'd6 || out_max !== 26'd20 || out_tie !== 1'b0) begin n_err++;
         $display("FAIL bubble_result got v %b idx %0d max %0d tie %b exp 1 6 20 0", out_valid, out_index, out_max, out_tie); end
      take_result();
   endtask

   task automatic test_flush();
      int pre[4] = '{50, 60, 70, 80};
      int sc[NC] = '{1, 2, 30, 4, 5, 6, 7, 8, 9, 10};
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = pre[i][NS-1:0];
         @(posedge clk); #1;
      end
      Flush = 1'b1; in_valid = 1'b1; in_data = 26'd99;
      @(posedge clk); #1;
      Flush = 1'b0; in_valid = 1'b0;
      n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++;
         $display("FAIL flush_state got ready %b valid %b exp 1 0", in_ready, out_valid); end
      for (int i = 0; i < NC; i++) begin
         in_valid = 1'b1; in_data = sc[i][NS-1:0];
         @(posedge clk); #1;
         if (i == NC - 2) begin
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_count got valid %b exp 0", out_valid); end
         end
      end
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b1 || out_index !== 4'd2 || out_max !== 26'd30 || out_tie !== 1'b0) begin n_err++;
         $display("FAIL flush_result got v %b idx %0d max %0d tie %b exp 1 2 30 0", out_valid, out_index, out_max, out_tie); end
      // Flush wins over a simultaneous output handshake and drops the result.
      Flush = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      Flush = 1'b0; out_ready = 1'b0;
      n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
         $display("FAIL flush_done got valid %b ready %b exp 0 1", out_valid, in_ready); end
   endtask

   task automatic test_reset_mid();
      int sc[NC] = '{7, 3, 3, 12, 0, 12, 1, 1, 1, 1};
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; in_data = 26'(40 + i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #2 GlobalReset = 1'b1;
      #1;
      n_vec++; if (out_index !== '0 || out_max !== '0 || out_tie !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
         $display("FAIL async_reset got idx %0d max %0d tie %b v %b r %b exp 0 0 0 0 1", out_index, out_max, out_tie, out_valid, in_ready); end
      GlobalReset = 1'b0;
      @(posedge clk); #1;
      drive_frame(sc);
      n_vec++; if (out_valid !== 1'b1 || out_index !== 4'd3 || out_max !== 26'd12 || out_tie !== 1'b1) begin n_err++;
         $display("FAIL post_reset got v %b idx %0d max %0d tie %b exp 1 3 12 1", out_valid, out_index, out_max, out_tie); end
      take_result();
   endtask

   task automatic test_back_to_back();
      int fi = 0, si = 0, pulses = 0, last_cyc = -1;
      logic took;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         in_valid = (fi < 3);
         in_data  = (si == fi + 4) ? 26'd100 : 26'(si);
         took = in_valid && in_ready;
         @(posedge clk); #1;
         if (took) begin
            si++;
            if (si == NC) begin si = 0; fi++; end
         end
         if (out_valid) begin
            n_vec++; if (out_index !== 4'(pulses + 4) || out_max !== 26'd100) begin n_err++;
               $display("FAIL b2b_result pulse %0d got idx %0d max %0d exp %0d 100", pulses, out_index, out_max, pulses + 4); end
            if (last_cyc >= 0) begin
               n_vec++; if (cyc - last_cyc !== 11) begin n_err++;
                  $display("FAIL b2b_period got %0d exp 11", cyc - last_cyc); end
            end
            last_cyc = cyc;
            pulses++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      n_vec++; if (pulses !== 3) begin n_err++; $display("FAIL b2b_pulses got %0d exp 3", pulses); end
   endtask

   initial begin
      test_reset();
      test_ties();
      test_hold();
      test_signed();
      test_signed_order();
      test_bubbles();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
